// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one 5-entry, 4-bit stack between requesters A and B.
//   Round-robin arbitration, occupancy tracking, illegal-op rejection, ACK pulse.
//   Latency: legal push/pop/get ACK two cycles after the grant edge; nop/reject ACK one cycle after.
//   Backpressure: REQ is a level held until ACK; REQ is ignored while BUSY (ISSUE/DONE).
// Ports:
//   clk_i, rst_i             clock, async active-high reset (shared with the stack)
//   a_/b_req_i,op_i,index_i,wdata_i   requester inputs (op: 00 nop, 01 push, 10 pop, 11 get)
//   a_/b_ack_o               one-cycle completion pulse to the granted requester
//   rdata_o, err_o           result and reject flag, valid while an ACK is high
//   count_o, busy_o          occupancy 0..5, high in ISSUE and DONE
//   stk_command_o, stk_index_o, stk_data_io   drive toward the stack
module stack_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_req_i,
  input  logic [1:0] a_op_i,
  input  logic [2:0] a_index_i,
  input  logic [3:0] a_wdata_i,
  input  logic       b_req_i,
  input  logic [1:0] b_op_i,
  input  logic [2:0] b_index_i,
  input  logic [3:0] b_wdata_i,
  output logic       a_ack_o,
  output logic       b_ack_o,
  output logic [3:0] rdata_o,
  output logic       err_o,
  output logic [2:0] count_o,
  output logic       busy_o,
  output logic [1:0] stk_command_o,
  output logic [2:0] stk_index_o,
  inout  wire  [3:0] stk_data_io
);

  localparam logic [2:0] DEPTH = 3'd5;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_GET  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t     state_q;
  logic       last_q;      // 1 = B was granted last
  logic       gnt_b_q;
  logic [1:0] op_q;
  logic [3:0] wdata_q;
  logic [2:0] count_q;
  logic       ack_a_q;
  logic       ack_b_q;
  logic       err_q;
  logic [3:0] rdata_q;
  logic [3:0] rdata_nxt_q;
  logic       busy_q;
  logic [1:0] stk_cmd_q;
  logic [2:0] stk_idx_q;
  logic       stk_drv_q;

  logic       any_req_d;
  logic       gnt_b_d;
  logic [1:0] op_d;
  logic [2:0] idx_d;
  logic [3:0] wdata_d;
  logic       legal_d;

  // Grant selection and legality of the request being granted this cycle.
  always_comb begin
    any_req_d = a_req_i | b_req_i;
    // On a tie, grant whoever was not served last.
    gnt_b_d   = b_req_i & (~a_req_i | ~last_q);
    op_d      = gnt_b_d ? b_op_i    : a_op_i;
    idx_d     = gnt_b_d ? b_index_i : a_index_i;
    wdata_d   = gnt_b_d ? b_wdata_i : a_wdata_i;
    legal_d   = 1'b1;
    case (op_d)
      OP_PUSH: legal_d = (count_q != DEPTH);
      OP_POP:  legal_d = (count_q != 3'd0);
      // count_q never exceeds 5, so indices 5..7 fail this test too.
      OP_GET:  legal_d = (idx_d < count_q);
      default: legal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_b_q   <= 1'b0;
      op_q      <= OP_NOP;
      wdata_q   <= 4'd0;
      count_q   <= 3'd0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 4'd0;
      busy_q    <= 1'b0;
      stk_cmd_q <= OP_NOP;
      stk_idx_q <= 3'd0;
      stk_drv_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            last_q  <= gnt_b_d;
            gnt_b_q <= gnt_b_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            busy_q  <= 1'b1;
            if (legal_d && (op_d != OP_NOP)) begin
              state_q   <= ISSUE;
              stk_cmd_q <= op_d;
              stk_idx_q <= (op_d == OP_GET) ? idx_d : 3'd0;
              stk_drv_q <= (op_d == OP_PUSH);
            end else begin
              // Rejected ops and nops complete without touching the stack.
              state_q <= DONE;
              ack_a_q <= ~gnt_b_d;
              ack_b_q <= gnt_b_d;
              err_q   <= ~legal_d;
            end
          end
        end
        ISSUE: begin
          state_q   <= DONE;
          stk_cmd_q <= OP_NOP;
          stk_idx_q <= 3'd0;
          stk_drv_q <= 1'b0;
          ack_a_q   <= ~gnt_b_q;
          ack_b_q   <= gnt_b_q;
          err_q     <= 1'b0;
          if (op_q == OP_PUSH) count_q <= count_q + 3'd1;
          if (op_q == OP_POP)  count_q <= count_q - 3'd1;
          if ((op_q == OP_POP) || (op_q == OP_GET)) rdata_q <= rdata_nxt_q;
        end
        DONE: begin
          // REQ is not sampled here; a still-high REQ is a new request in IDLE.
          state_q <= IDLE;
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The stack only drives IO_DATA while the clock is high, so read data is
  // sampled on the falling edge inside ISSUE and moved to rdata_q afterwards.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_nxt_q <= 4'd0;
    end else if ((state_q == ISSUE) && ((op_q == OP_POP) || (op_q == OP_GET))) begin
      rdata_nxt_q <= stk_data_io;
    end
  end

  assign stk_data_io   = stk_drv_q ? wdata_q : 4'bzzzz;
  assign stk_command_o = stk_cmd_q;
  assign stk_index_o   = stk_idx_q;
  assign a_ack_o       = ack_a_q;
  assign b_ack_o       = ack_b_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign count_o       = count_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Testbench for stack_arbiter with a behavioural mod-5 stack attached.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [1:0] a_op = 2'd0, b_op = 2'd0;
  logic [2:0] a_index = 3'd0, b_index = 3'd0;
  logic [3:0] a_wdata = 4'd0, b_wdata = 4'd0;
  logic       a_ack, b_ack, err, busy;
  logic [3:0] rdata;
  logic [2:0] count;
  logic [1:0] stk_cmd;
  logic [2:0] stk_idx;
  wire  [3:0] stk_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       who;
    logic       err;
    logic [3:0] rdata;
    logic [2:0] count;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  stack_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_op_i(a_op), .a_index_i(a_index), .a_wdata_i(a_wdata),
    .b_req_i(b_req), .b_op_i(b_op), .b_index_i(b_index), .b_wdata_i(b_wdata),
    .a_ack_o(a_ack), .b_ack_o(b_ack), .rdata_o(rdata), .err_o(err),
    .count_o(count), .busy_o(busy),
    .stk_command_o(stk_cmd), .stk_index_o(stk_idx), .stk_data_io(stk_data)
  );

  // Behavioural stack: head wraps mod 5, drives IO_DATA only while clk is high.
  logic [3:0] mem [5];
  int         head = 0;
  logic       s_drv = 1'b0;
  logic [3:0] s_val = 4'd0;
  assign stk_data = s_drv ? s_val : 4'bzzzz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= 0;
    end else if (stk_cmd == 2'b01) begin
      mem[head] <= stk_data;
      head <= (head == 4) ? 0 : head + 1;
    end else if (stk_cmd == 2'b10) begin
      head <= (head == 0) ? 4 : head - 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst && (stk_cmd == 2'b10 || stk_cmd == 2'b11)) begin
      s_val <= mem[(head + 10 - 1 - ((stk_cmd == 2'b11) ? int'(stk_idx) : 0)) % 5];
      s_drv <= 1'b1;
    end
  end

  always @(negedge clk) begin
    #1;
    s_drv <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ACK must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && (a_ack || b_ack)) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_who", {31'd0, b_ack}, {31'd0, e.who});
        check("ack_single", {31'd0, a_ack & b_ack}, 32'd0);
        check("ack_err", {31'd0, err}, {31'd0, e.err});
        check("ack_rdata", {28'd0, rdata}, {28'd0, e.rdata});
        check("ack_count", {29'd0, count}, {29'd0, e.count});
      end
    end
  end

  task automatic do_op(input logic who, input logic [1:0] op, input logic [2:0] idx,
                       input logic [3:0] wd, input logic exp_err,
                       input logic [3:0] exp_rd, input logic [2:0] exp_cnt);
    int  cyc;
    int  lat;
    logic got;
    lat = (!exp_err && op != 2'b00) ? 2 : 1;
    @(negedge clk);
    if (!who) begin
      a_req = 1'b1; a_op = op; a_index = idx; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_op = op; b_index = idx; b_wdata = wd;
    end
    sb.push_back('{who: who, err: exp_err, rdata: exp_rd, count: exp_cnt});
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 10) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1 && lat == 2) begin
        check("issue_cmd", {30'd0, stk_cmd}, {30'd0, op});
        check("issue_idx", {29'd0, stk_idx}, {29'd0, (op == 2'b11) ? idx : 3'd0});
        check("issue_busy", {31'd0, busy}, 32'd1);
        if (op == 2'b01) check("issue_data", {28'd0, stk_data}, {28'd0, wd});
      end
      got = who ? b_ack : a_ack;
      if (got) check("done_cmd", {30'd0, stk_cmd}, 32'd0);
    end
    check("latency", cyc, lat);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, cyc, last_ack;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ack", {30'd0, a_ack, b_ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", {28'd0, rdata}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd", {27'd0, stk_cmd, stk_idx}, 32'd0);
    rst = 1'b0;

    // Single push, then empty again
    do_op(1'b0, 2'b01, 3'd0, 4'h3, 1'b0, 4'h0, 3'd1);
    do_op(1'b0, 2'b10, 3'd0, 4'h0, 1'b0, 4'h3, 3'd0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++)
      do_op(1'b0, 2'b01, 3'd0, 4'(i), 1'b0, 4'h3, 3'(i));
    do_op(1'b0, 2'b01, 3'd0, 4'h6, 1'b1, 4'h3, 3'd5);

    // Pop order and underflow
    for (int i = 5; i >= 1; i--)
      do_op(1'b1, 2'b10, 3'd0, 4'h0, 1'b0, 4'(i), 3'(i - 1));
    do_op(1'b1, 2'b10, 3'd0, 4'h0, 1'b1, 4'h1, 3'd0);

    // Get
    do_op(1'b1, 2'b01, 3'd0, 4'h7, 1'b0, 4'h1, 3'd1);
    do_op(1'b1, 2'b01, 3'd0, 4'h8, 1'b0, 4'h1, 3'd2);
    do_op(1'b1, 2'b01, 3'd0, 4'h9, 1'b0, 4'h1, 3'd3);
    do_op(1'b0, 2'b11, 3'd0, 4'h0, 1'b0, 4'h9, 3'd3);
    do_op(1'b0, 2'b11, 3'd2, 4'h0, 1'b0, 4'h7, 3'd3);
    do_op(1'b0, 2'b11, 3'd3, 4'h0, 1'b1, 4'h7, 3'd3);
    do_op(1'b1, 2'b11, 3'd6, 4'h0, 1'b1, 4'h7, 3'd3);
    do_op(1'b1, 2'b00, 3'd0, 4'h0, 1'b0, 4'h7, 3'd3);

    // Arbitration with both requesters held high from a fresh reset
    do_reset();
    check("rst2_count", {29'd0, count}, 32'd0);
    @(negedge clk);
    sb.push_back('{who: 1'b0, err: 1'b0, rdata: 4'h0, count: 3'd1});
    sb.push_back('{who: 1'b1, err: 1'b0, rdata: 4'h0, count: 3'd2});
    sb.push_back('{who: 1'b0, err: 1'b0, rdata: 4'h0, count: 3'd3});
    sb.push_back('{who: 1'b1, err: 1'b0, rdata: 4'h0, count: 3'd4});
    a_req = 1'b1; a_op = 2'b01; a_wdata = 4'hA;
    b_req = 1'b1; b_op = 2'b01; b_wdata = 4'hB;
    n = 0; cyc = 0; last_ack = 0;
    while (n < 4 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (a_ack || b_ack) begin
        if (n > 0) check("ack_gap", {31'd0, (cyc - last_ack) >= 3}, 32'd1);
        last_ack = cyc;
        n++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("arb_acks", n, 4);
    do_op(1'b0, 2'b10, 3'd0, 4'h0, 1'b0, 4'hB, 3'd3);
    do_op(1'b0, 2'b10, 3'd0, 4'h0, 1'b0, 4'hA, 3'd2);
    do_op(1'b0, 2'b10, 3'd0, 4'h0, 1'b0, 4'hB, 3'd1);
    do_op(1'b0, 2'b10, 3'd0, 4'h0, 1'b0, 4'hA, 3'd0);

    // Reset during ISSUE of a push
    @(negedge clk);
    a_req = 1'b1; a_op = 2'b01; a_wdata = 4'h5;
    @(posedge clk);
    @(negedge clk);
    check("mid_issue_cmd", {30'd0, stk_cmd}, 32'd1);
    check("mid_issue_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", {30'd0, a_ack, b_ack}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_rdata", {28'd0, rdata}, 32'd0);
    check("mid_rst_cmd", {27'd0, stk_cmd, stk_idx}, 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
    end
    do_op(1'b0, 2'b10, 3'd0, 4'h0, 1'b1, 4'h0, 3'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Two-port controller that shares one 5-entry, 4-bit `stack` instance between requesters A and B. It arbitrates round-robin and tracks occupancy, which the stack itself does not do because its head wraps mod 5 silently. Illegal operations (push when full, pop when empty, get out of range) are rejected without touching the stack. For each accepted operation it drives COMMAND/INDEX/IO_DATA toward the stack and returns read data with a one-cycle acknowledge.

## Interface
- DEPTH, 5, stack capacity; fixed to match the mod-5 stack head.
- W, 4, data width; fixed to match stack IO_DATA.
- CLK  in  1  single clock; all state updates on rising edge except read capture (see Timing).
- RESET  in  1  asynchronous, active-high; same net also resets the stack.
- A_REQ / B_REQ  in  1  request, level, held until the matching ACK.
- A_OP / B_OP  in  2  00 nop, 01 push, 10 pop, 11 get.
- A_INDEX / B_INDEX  in  3  get depth; 0 = top of stack.
- A_WDATA / B_WDATA  in  4  push data.
- A_ACK / B_ACK  out  1  one-cycle completion pulse to the granted requester.
- RDATA  out  4  pop/get result; valid while an ACK is high, otherwise holds.
- ERR  out  1  operation rejected; valid while an ACK is high.
- COUNT  out  3  current occupancy, 0..5.
- BUSY  out  1  high in ISSUE and DONE.
- STK_COMMAND  out  2  to stack COMMAND.
- STK_INDEX  out  3  to stack INDEX.
- STK_DATA  inout  4  to stack IO_DATA.

## Operation
- **FSM states:** IDLE, ISSUE, DONE.
- **IDLE:**
  - No REQ: stay in IDLE.
  - One REQ: grant that requester.
  - Both REQ: grant the requester other than LAST; LAST resets to B, so A wins the first tie.
  - On grant, latch OP/INDEX/WDATA and set LAST to the grantee.
- **Legality check (in IDLE, on latched values):**
  - Push is illegal when COUNT=5.
  - Pop is illegal when COUNT=0.
  - Get is illegal when INDEX ≥ COUNT; INDEX 5..7 is always illegal.
  - Nop is always legal.
- **Transitions:**
  - Legal push, pop or get: IDLE→ISSUE→DONE→IDLE.
  - Illegal op or nop: IDLE→DONE with ERR=1 for illegal, ERR=0 for nop. The stack sees no command.
- **ISSUE:**
  - STK_COMMAND = OP and STK_INDEX = INDEX for get, else 000.
  - STK_DATA driven with WDATA for push; high-Z for every other op.
- **Count update on the ISSUE→DONE edge:** push +1, pop −1, get unchanged.
- **DONE:**
  - Granted ACK = 1 for exactly one cycle.
  - ERR valid; RDATA valid for pop/get.
  - STK_COMMAND = 00; STK_DATA high-Z.
  - DONE→IDLE is unconditional; REQ is not sampled in DONE.
- **Requester rule:** deassert REQ by the rising edge that ends the ACK cycle. REQ still high when next sampled in IDLE is a new request.
- **Outside ISSUE:** STK_COMMAND = 00, STK_INDEX = 000, STK_DATA = Z.
- **RESET mid-operation:** abort the op with no ACK and return to IDLE. COUNT=0 is consistent with the stack reset.

## Timing
- **Reset values:**
  - A_ACK = B_ACK = 0, ERR = 0, RDATA = 0000.
  - COUNT = 000, BUSY = 0.
  - STK_COMMAND = 00, STK_INDEX = 000, STK_DATA = Z.
  - State = IDLE, LAST = B.
- **Latency:**
  - REQ sampled at edge N (in IDLE) → ISSUE in cycle N+1 → ACK in cycle N+2.
  - Rejected op or nop: ACK in cycle N+1.
- **Throughput:** back-to-back legal ops from alternating requesters take one op per 3 cycles (IDLE, ISSUE, DONE).
- **Read capture:** during ISSUE the stack drives IO_DATA only while CLK is high. RDATA_next is captured on the falling CLK edge inside ISSUE and transferred to RDATA at the ISSUE→DONE rising edge.
- **No contention:** STK_DATA is driven only for push, and push is never a read command.
- **Held command:** STK_COMMAND/INDEX/DATA are stable for the full ISSUE cycle, which covers the whole stack write window and the head update.

## Test plan
- **Reset then single push:** reset, A pushes 0x3.
  - ACK_A in cycle N+2, ERR=0, COUNT=1.
  - STK_COMMAND=01 and STK_DATA=0x3 during ISSUE only.
- **Fill and overflow:** push 1,2,3,4,5 (COUNT=5), then push 6.
  - Sixth push: ACK in N+1, ERR=1, STK_COMMAND stays 00, COUNT stays 5.
- **Pop order and underflow:** after the fill, pop ×5.
  - RDATA = 5,4,3,2,1; COUNT ends at 0.
  - Sixth pop: ERR=1, RDATA unchanged.
- **Get:** with 7,8,9 pushed:
  - get 0 → 9; get 2 → 7; COUNT stays 3.
  - get 3 → ERR=1; get 6 → ERR=1.
- **Arbitration:** A_REQ and B_REQ both high continuously with pushes A=0xA, B=0xB.
  - Grants alternate A,B,A,B; every ACK is ≥3 cycles apart.
  - Pop ×4 returns B,A,B,A.
- **Reset mid-operation:** assert RESET during ISSUE of a push.
  - No ACK; all outputs at reset values immediately.
  - A subsequent pop returns ERR=1.
